// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder for a CPU load/store port.
// A request is accepted only in IDLE, waits LATENCY cycles, then the
// response is held until the CPU takes it. Store data is committed and
// load data captured on the edge that enters RESP.
//
// Optional feature (macro DMEM_RANGE_CHECK_EN):
//   defined   -> out-of-range or misaligned requests complete with
//                rsp_err = 1, rdata = 0 and no store.
//   undefined -> addresses wrap modulo DEPTH words, rsp_err stays 0.
//
// Parameters:
//   DEPTH    number of 32-bit words (power of two, 4..4096)
//   LATENCY  cycles from accept to rsp_valid (1..15)
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_req_valid      request present
//   i_req_write      1 = store, 0 = load
//   i_req_addr       byte address
//   i_req_wdata      store data
//   o_req_ready      request can be accepted this cycle
//   o_rsp_valid      response available
//   i_rsp_ready      CPU takes the response
//   o_rsp_rdata      load data (0 for stores / errors)
//   o_rsp_err        request rejected
//   o_access_count   completed transactions, saturating
//
// State | meaning
// ------+---------------------------------------------------------
// IDLE  | ready for a new request
// WAIT  | latency countdown, counter reaches 0 on last WAIT cycle
// RESP  | response held until rsp_ready handshake
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_access_count
);

    localparam int         AW           = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD     = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
    localparam bit         SINGLE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_write;
    logic [AW-1:0]  r_idx;
    logic [31:0]    r_wdata;
    logic           r_err;
    logic           r_rsp_valid;
    logic           r_rsp_err;
    logic [31:0]    r_rsp_rdata;
    logic [31:0]    r_access_count;
    logic [31:0]    r_mem [DEPTH];

    logic           w_accept;
    logic           w_req_err;
    logic           w_use_in;
    logic           w_write;
    logic           w_err;
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_wdata;
    logic           w_enter_resp;
    logic           w_commit;
    logic [31:0]    w_load;

    // Ready is masked by reset so it reads 0 while reset is held.
    assign o_req_ready = i_rst_n && (r_state == S_IDLE);
    assign w_accept    = i_req_valid && o_req_ready;

`ifdef DMEM_RANGE_CHECK_EN
    assign w_req_err = (i_req_addr >= 32'(4 * DEPTH)) || (i_req_addr[1:0] != 2'b00);
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{i_req_addr[31:AW+2], i_req_addr[1:0]};
    assign w_req_err     = 1'b0;
`endif

    // With LATENCY = 1 the accept edge is also the RESP entry edge, so the
    // request fields come straight from the inputs instead of the latches.
    assign w_use_in = (r_state == S_IDLE);
    assign w_write  = w_use_in ? i_req_write           : r_write;
    assign w_idx    = w_use_in ? i_req_addr[AW+1:2]    : r_idx;
    assign w_wdata  = w_use_in ? i_req_wdata           : r_wdata;
    assign w_err    = w_use_in ? w_req_err             : r_err;

    assign w_enter_resp = (w_accept && SINGLE_CYCLE) ||
                          ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign w_commit     = w_enter_resp && w_write && !w_err;
    assign w_load       = r_mem[w_idx];

    // Array has no reset so its contents survive a reset pulse.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= 4'd0;
            r_write        <= 1'b0;
            r_idx          <= '0;
            r_wdata        <= 32'd0;
            r_err          <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_rsp_rdata    <= 32'd0;
            r_access_count <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write <= i_req_write;
                        r_idx   <= i_req_addr[AW+1:2];
                        r_wdata <= i_req_wdata;
                        r_err   <= w_req_err;
                        r_cnt   <= CNT_LOAD;
                        r_state <= SINGLE_CYCLE ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        if (r_access_count != 32'hFFFF_FFFF) begin
                            r_access_count <= r_access_count + 32'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Never true in RESP, so it cannot collide with the handshake above.
            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_write || w_err) ? 32'd0 : w_load;
            end
        end
    end

    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_err      = r_rsp_err;
    assign o_access_count = r_access_count;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be: DEPTH, default 256, number of 32-bit words (power of two, 4..4096); LATENCY, default 2, cycles from request accept to rsp_valid (1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU presents a memory request.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  store data.
REQ-008 req_ready  output  1  responder can accept a request this cycle.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  CPU accepts the response.
REQ-011 rsp_rdata  output  32  load data; 0 for stores.
REQ-012 rsp_err  output  1  request rejected (see Configuration).
REQ-013 access_count  output  32  number of completed transactions.

Function
REQ-014 Word index SHALL be req_addr[log2(DEPTH)+1:2]; req_addr[1:0] is ignored for indexing.
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 A request is accepted on an edge with req_valid && req_ready; write, index, wdata SHALL be latched at that edge; later input changes are ignored.
REQ-017 On accept: LATENCY = 1 -> RESP; otherwise -> WAIT with the wait counter loaded with LATENCY-2.
REQ-018 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-019 rsp_valid SHALL rise exactly LATENCY cycles after the accept edge.
REQ-020 Store SHALL commit to the array on the edge entering RESP; load data SHALL be captured on the same edge and held stable in RESP.
REQ-021 RESP: rsp_valid = 1 until the edge with rsp_ready = 1, then -> IDLE; rsp_valid and rsp_err return to 0 in IDLE.
REQ-022 A new request SHALL be accepted no earlier than the cycle after the response handshake; throughput is one transaction per LATENCY+1 cycles with rsp_ready held at 1.
REQ-023 access_count SHALL increment by 1 on each response handshake, including errored ones, and saturate at 0xFFFFFFFF.
REQ-024 A load following a store to the same word SHALL return the stored value.
REQ-025 req_valid while not in IDLE SHALL have no effect.

Reset
REQ-026 reset low SHALL immediately force: state IDLE, req_ready 0 while asserted then 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, access_count 0, wait counter 0.
REQ-027 Reset during WAIT SHALL abort the transaction with no store committed; reset in RESP discards the pending response.
REQ-028 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro DMEM_RANGE_CHECK_EN defined: a request with req_addr >= 4*DEPTH or req_addr[1:0] != 0 SHALL complete with normal timing, rsp_err = 1 in RESP, rsp_rdata = 0, and no store committed.
REQ-030 Macro undefined: out-of-range addresses SHALL wrap modulo DEPTH words, misalignment is ignored, and rsp_err is tied to 0.

Verification
REQ-031 Reset release; store 0xDEADBEEF at 0x10 with LATENCY=2, rsp_ready=1 -> rsp_valid high at cycle accept+2 for 1 cycle, rsp_rdata=0, access_count=1.
REQ-032 Load 0x10 immediately after the store -> rsp_rdata=0xDEADBEEF, access_count=2, req_ready low from accept until after the handshake.
REQ-033 Load with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable for all 5 cycles, single access_count increment after the handshake.
REQ-034 Store 0x12345678 at 0x20, reset pulsed low in WAIT, then load 0x20 -> old value returned, access_count=1 after the load.
REQ-035 With DMEM_RANGE_CHECK_EN: store at 0x400 (DEPTH=256) -> rsp_err=1, word 0 unchanged; without the macro: the same store writes word 0 and rsp_err=0.
REQ-036 LATENCY=1, 10 back-to-back loads with req_valid and rsp_ready held 1 -> one response every 2 cycles, access_count=10.
